button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Conditions one raw push-button (clr / ent / change) before it reaches the ASM.
//   Synchronises, debounces, then emits a clean level, single-cycle press/release
//   pulses and an optional auto-repeat "action" pulse for held buttons.
//   One instance per button, all running on the slow control clock that also drives the ASM.
// PARAMETERS
//   DEBOUNCE_CYCLES  4   consecutive disagreeing samples required to change state (>=1)
//   REPEAT_DELAY     50  cycles from press pulse to first repeat pulse (>=1)
//   REPEAT_PERIOD    10  cycles between subsequent repeat pulses (>=1)
//   CNT_W            8   width of internal counters; must hold max(all three params)
// PORTS
//   clk            in   1  control clock; all logic on rising edge
//   rst            in   1  synchronous reset, active-high
//   btn_in         in   1  raw asynchronous button input, active-high
//   repeat_en      in   1  1 = auto-repeat allowed while held
//   btn_level      out  1  debounced button level
//   press_pulse    out  1  one cycle high on debounced 0->1
//   release_pulse  out  1  one cycle high on debounced 1->0
//   repeat_pulse   out  1  one cycle high per auto-repeat event
//   action_pulse   out  1  press_pulse | repeat_pulse (registered, same cycle as sources)
// BEHAVIOUR
//   - Reset: every output 0, sync flops 0, counters 0, FSM IDLE; takes effect on the
//     next edge regardless of state (reset mid-hold or mid-debounce discards all progress).
//   - Sync: two-flop chain btn_in -> s1 -> s2; only s2 used downstream.
//   - Debounce: counter dcnt increments on each edge where s2 != btn_level, clears on any
//     edge where s2 == btn_level. On an edge where s2 != btn_level and dcnt == DEBOUNCE_CYCLES-1:
//     btn_level <= s2, dcnt <= 0, and press_pulse or release_pulse set for the following cycle.
//   - Latency: btn_in held stable across edges -> btn_level/press_pulse change on edge
//     DEBOUNCE_CYCLES+2 after btn_in changes (edge 1 = first edge sampling new value).
//   - Glitch shorter than DEBOUNCE_CYCLES samples at s2: no output change, dcnt returns to 0.
//   - All pulses are registered and exactly one cycle wide; press and release never coincide.
//   - FSM (repeat): IDLE, HELD, REPEAT.
//     IDLE  : on debounced press -> HELD, rcnt <= 0.
//     HELD  : rcnt increments each edge; if repeat_en and rcnt == REPEAT_DELAY-1 ->
//             repeat_pulse next cycle, rcnt <= 0, -> REPEAT.
//     REPEAT: rcnt increments; if repeat_en and rcnt == REPEAT_PERIOD-1 -> repeat_pulse,
//             rcnt <= 0, stay.
//     Any state: debounced release -> IDLE, rcnt <= 0, no repeat_pulse on that edge
//     (release wins over a coincident repeat).
//     repeat_en low in HELD/REPEAT: rcnt held at 0, no repeats, state kept; repeats resume
//     a full delay/period after repeat_en returns high.
//   - First repeat_pulse arrives REPEAT_DELAY cycles after press_pulse; next ones every
//     REPEAT_PERIOD cycles. rcnt saturates never; it is always cleared before overflow.
//   - press_pulse and repeat_pulse never coincide (press only from IDLE).
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//   1. rst high 2 cycles, btn_in=1 throughout -> all outputs 0 during reset; after release
//      btn_level=1 and press_pulse=1 for one cycle 6 edges after rst drops.
//   2. btn_in 0->1 held 30 cycles, repeat_en=0 -> press_pulse once at edge 6, btn_level=1,
//      repeat_pulse never; btn_in ->0 -> release_pulse once 6 edges later.
//   3. btn_in bounces 1,0,1,0 (1-cycle each) then steady 1 -> no pulse until 4 stable s2
//      samples; exactly one press_pulse.
//   4. Held with repeat_en=1 for 25 cycles after press -> repeat_pulse at press+10,+13,+16,
//      +19,+22,+25; action_pulse = 7 pulses total including press.
//   5. Release debounced on same edge a repeat would fire -> release_pulse=1, repeat_pulse=0,
//      FSM IDLE.
//   6. rst asserted mid-REPEAT -> next cycle all outputs 0, FSM IDLE; button still held ->
//      fresh press_pulse 6 edges after rst deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, counter debounce, registered
// press/release pulses and an auto-repeat FSM for held buttons.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 50,
   parameter int REPEAT_PERIOD   = 10,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic repeat_en,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse,
   output logic action_pulse
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

   logic             s1, s2;
   logic [CNT_W-1:0] dcnt, dcnt_d;
   logic [CNT_W-1:0] rcnt, rcnt_d;
   state_t           state, state_d;
   logic             level_d, rise, fall, rep_d;

   // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      dcnt_d  = '0;
      level_d = btn_level;
      rise    = 1'b0;
      fall    = 1'b0;
      if (s2 != btn_level) begin
         if (dcnt == DB_LAST) begin
            level_d = s2;
            rise    = s2;
            fall    = ~s2;
         end else begin
            dcnt_d = dcnt + 1'b1;
         end
      end
   end

   // Repeat FSM; a debounced release overrides any repeat due on the same edge.
   always_comb begin
      state_d = state;
      rcnt_d  = rcnt;
      rep_d   = 1'b0;
      if (fall) begin
         state_d = IDLE;
         rcnt_d  = '0;
      end else begin
         case (state)
            IDLE: begin
               rcnt_d = '0;
               if (rise) state_d = HELD;
            end
            HELD: begin
               if (!repeat_en) begin
                  rcnt_d = '0;
               end else if (rcnt == DLY_LAST) begin
                  rep_d   = 1'b1;
                  rcnt_d  = '0;
                  state_d = REPEAT;
               end else begin
                  rcnt_d = rcnt + 1'b1;
               end
            end
            REPEAT: begin
               if (!repeat_en) begin
                  rcnt_d = '0;
               end else if (rcnt == PER_LAST) begin
                  rep_d  = 1'b1;
                  rcnt_d = '0;
               end else begin
                  rcnt_d = rcnt + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               rcnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         dcnt          <= '0;
         rcnt          <= '0;
         state         <= IDLE;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         repeat_pulse  <= 1'b0;
         action_pulse  <= 1'b0;
      end else begin
         s1            <= btn_in;
         s2            <= s1;
         dcnt          <= dcnt_d;
         rcnt          <= rcnt_d;
         state         <= state_d;
         btn_level     <= level_d;
         press_pulse   <= rise;
         release_pulse <= fall;
         repeat_pulse  <= rep_d;
         action_pulse  <= rise | rep_d;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_conditioner;

   logic clk = 1'b0;
   logic rst, btn_in, repeat_en;
   logic btn_level, press_pulse, release_pulse, repeat_pulse, action_pulse;

   int errors = 0;
   int checks = 0;

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(3),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .repeat_en(repeat_en),
      .btn_level(btn_level),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .repeat_pulse(repeat_pulse),
      .action_pulse(action_pulse)
   );

   always #5 clk = ~clk;

   // Output vector ordering: {level, press, release, repeat, action}
   typedef struct {
      logic       rst;
      logic       btn;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[21];

   function automatic logic [4:0] outs();
      return {btn_level, press_pulse, release_pulse, repeat_pulse, action_pulse};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int idx, input logic [4:0] got, input logic [4:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %b expected %b (level,press,release,repeat,action)", name, idx, got, exp);
      end
   endtask

   // Drive n edges with constant inputs; expected outputs derived from event edges (0 = none).
   task automatic run_seg(input string name, input int n, input logic btn, input logic ren,
                          input logic lvl_in, input int press_at, input int rel_at,
                          input int rep_first, input int rep_last, input int period);
      logic       lvl;
      logic       p, r, q;
      lvl = lvl_in;
      btn_in    = btn;
      repeat_en = ren;
      for (int e = 1; e <= n; e++) begin
         tick();
         p = (e == press_at);
         r = (e == rel_at);
         q = (rep_first > 0) && (e >= rep_first) && (e <= rep_last) &&
             (((e - rep_first) % period) == 0);
         if (p) lvl = 1'b1;
         if (r) lvl = 1'b0;
         check(name, e, outs(), {lvl, p, r, q, p | q});
      end
   endtask

   initial begin
      // Reset with button held, then press, release, and a short glitch.
      tbl[0]  = '{1'b1, 1'b1, 5'b00000};
      tbl[1]  = '{1'b1, 1'b1, 5'b00000};
      tbl[2]  = '{1'b0, 1'b1, 5'b00000};
      tbl[3]  = '{1'b0, 1'b1, 5'b00000};
      tbl[4]  = '{1'b0, 1'b1, 5'b00000};
      tbl[5]  = '{1'b0, 1'b1, 5'b00000};
      tbl[6]  = '{1'b0, 1'b1, 5'b00000};
      tbl[7]  = '{1'b0, 1'b1, 5'b11001};
      tbl[8]  = '{1'b0, 1'b1, 5'b10000};
      tbl[9]  = '{1'b0, 1'b0, 5'b10000};
      tbl[10] = '{1'b0, 1'b0, 5'b10000};
      tbl[11] = '{1'b0, 1'b0, 5'b10000};
      tbl[12] = '{1'b0, 1'b0, 5'b10000};
      tbl[13] = '{1'b0, 1'b0, 5'b10000};
      tbl[14] = '{1'b0, 1'b0, 5'b00100};
      tbl[15] = '{1'b0, 1'b0, 5'b00000};
      tbl[16] = '{1'b0, 1'b1, 5'b00000};
      tbl[17] = '{1'b0, 1'b1, 5'b00000};
      tbl[18] = '{1'b0, 1'b0, 5'b00000};
      tbl[19] = '{1'b0, 1'b0, 5'b00000};
      tbl[20] = '{1'b0, 1'b0, 5'b00000};

      rst       = 1'b1;
      btn_in    = 1'b1;
      repeat_en = 1'b0;
      for (int i = 0; i < 21; i++) begin
         rst    = tbl[i].rst;
         btn_in = tbl[i].btn;
         tick();
         check("table", i, outs(), tbl[i].exp);
      end

      // Held 30 cycles with repeat disabled, then release.
      run_seg("hold_norep", 30, 1'b1, 1'b0, 1'b0, 6, 0, 0, 0, 1);
      run_seg("rel_norep", 8, 1'b0, 1'b0, 1'b1, 0, 6, 0, 0, 1);

      // Bounce 1,0,1,0 then steady high: press four stable samples later.
      for (int i = 0; i < 4; i++) begin
         btn_in = (i % 2 == 0);
         tick();
         check("bounce", i, outs(), 5'b00000);
      end
      run_seg("bounce_hold", 8, 1'b1, 1'b0, 1'b0, 6, 0, 0, 0, 1);
      run_seg("bounce_rel", 8, 1'b0, 1'b0, 1'b1, 0, 6, 0, 0, 1);

      // Auto-repeat: press at 6, repeats at 16,19,...,31; release lands on a repeat edge.
      run_seg("repeat_hold", 31, 1'b1, 1'b1, 1'b0, 6, 0, 16, 31, 3);
      run_seg("repeat_rel", 14, 1'b0, 1'b1, 1'b1, 0, 6, 3, 3, 3);

      // Reset while in REPEAT, button still held: fresh press after reset.
      run_seg("pre_rst", 20, 1'b1, 1'b1, 1'b0, 6, 0, 16, 19, 3);
      rst = 1'b1;
      tick();
      check("mid_rst", 0, outs(), 5'b00000);
      rst = 1'b0;
      run_seg("post_rst", 17, 1'b1, 1'b1, 1'b0, 6, 0, 16, 16, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
